// File: rtl/data_sram_stbuf.sv
// Data SRAM responder: word-addressed single-port array behind a one-entry store buffer.
// Loads own the array port. Buffered bytes are forwarded into loads of the same word.
module data_sram_stbuf #(
    parameter int ADDR_WIDTH = 10,
    parameter bit INIT_ZERO  = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stbuf_valid,
    output logic [15:0] drain_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_SWEEP,
        ST_RUN
    } state_e;

    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    logic [31:0]           mem_q [DEPTH];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sweep_idx_q, sweep_idx_d;
    logic                  buf_valid_q, buf_valid_d;
    logic [ADDR_WIDTH-1:0] buf_idx_q, buf_idx_d;
    logic [31:0]           buf_data_q, buf_data_d;
    logic [3:0]            buf_strb_q, buf_strb_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [15:0]           drain_cnt_q, drain_cnt_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wstrb;

    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  run, is_load, is_store, is_idle, buf_hit;
    logic [31:0]           fwd_mask, st_mask;
    logic                  unused_addr;

    assign req_idx     = data_sram_addr[ADDR_WIDTH+1:2];
    assign unused_addr = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

    assign run      = (state_q == ST_RUN);
    assign is_load  = run & data_sram_en & (data_sram_we == 4'h0);
    assign is_store = run & data_sram_en & (data_sram_we != 4'h0);
    assign is_idle  = run & ~data_sram_en;
    assign buf_hit  = buf_valid_q & (buf_idx_q == req_idx);
    assign fwd_mask = lane_mask(buf_strb_q) & {32{buf_hit}};
    assign st_mask  = lane_mask(data_sram_we);

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        buf_valid_d = buf_valid_q;
        buf_idx_d   = buf_idx_q;
        buf_data_d  = buf_data_q;
        buf_strb_d  = buf_strb_q;
        rdata_d     = rdata_q;
        drain_cnt_d = drain_cnt_q;
        mem_we      = 1'b0;
        mem_waddr   = buf_idx_q;
        mem_wdata   = buf_data_q;
        mem_wstrb   = buf_strb_q;

        if (state_q == ST_SWEEP) begin
            mem_we      = 1'b1;
            mem_waddr   = sweep_idx_q;
            mem_wdata   = 32'h0;
            mem_wstrb   = 4'hF;
            sweep_idx_d = sweep_idx_q + 1'b1;
            if (sweep_idx_q == '1) state_d = ST_RUN;
        end

        if (is_load) begin
            rdata_d = (mem_q[req_idx] & ~fwd_mask) | (buf_data_q & fwd_mask);
        end else if (is_store) begin
            if (buf_hit) begin
                buf_data_d = (buf_data_q & ~st_mask) | (data_sram_wdata & st_mask);
                buf_strb_d = buf_strb_q | data_sram_we;
            end else begin
                // A valid entry for another word is evicted in the same cycle it is replaced.
                if (buf_valid_q) begin
                    mem_we      = 1'b1;
                    drain_cnt_d = drain_cnt_q + 16'd1;
                end
                buf_valid_d = 1'b1;
                buf_idx_d   = req_idx;
                buf_data_d  = data_sram_wdata & st_mask;
                buf_strb_d  = data_sram_we;
            end
        end else if (is_idle && buf_valid_q) begin
            mem_we      = 1'b1;
            buf_valid_d = 1'b0;
            drain_cnt_d = drain_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= INIT_ZERO ? ST_SWEEP : ST_RUN;
            sweep_idx_q <= '0;
            buf_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            drain_cnt_q <= 16'h0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            buf_valid_q <= buf_valid_d;
            rdata_q     <= rdata_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Payload fields are qualified by buf_valid_q and need no reset.
    always_ff @(posedge clk) begin
        buf_idx_q  <= buf_idx_d;
        buf_data_q <= buf_data_d;
        buf_strb_q <= buf_strb_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wstrb[i]) mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign stbuf_valid     = buf_valid_q;
    assign drain_cnt       = drain_cnt_q;

endmodule
